// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
//   Bundles the request and register-file write-back signals of muldiv_unit.
//   master : drives run/start/op/operands/rd_in and observes the status and result.
//   slave  : the muldiv_unit side.
//   Request : run, start, op[1:0], rs1_val, rs2_val, rd_in
//   Response: busy, done, we, rd, rd_din
interface muldiv_unit_if #(
  parameter int BITS  = 8,
  parameter int RBITS = 3
);
  logic             run;
  logic             start;
  logic [1:0]       op;
  logic [BITS-1:0]  rs1_val;
  logic [BITS-1:0]  rs2_val;
  logic [RBITS-1:0] rd_in;
  logic             busy;
  logic             done;
  logic             we;
  logic [RBITS-1:0] rd;
  logic [BITS-1:0]  rd_din;

  modport master (
    output run, start, op, rs1_val, rs2_val, rd_in,
    input  busy, done, we, rd, rd_din
  );

  modport slave (
    input  run, start, op, rs1_val, rs2_val, rd_in,
    output busy, done, we, rd, rd_din
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative unsigned multiply/divide unit with register-file write-back.
//   One iteration per advancing cycle (run=1): shift-add multiply or
//   restoring shift-subtract divide, 8 iterations, result on done.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - muldiv_unit_if.slave:
//              run (advance enable), start, op (00 MUL, 01 MULHU, 10 DIVU, 11 REMU),
//              rs1_val, rs2_val, rd_in in; busy, done, we, rd, rd_din out
module muldiv_unit #(
  parameter int BITS  = 8,
  parameter int RBITS = 3
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last value of the 3-bit iteration counter; one iteration per operand bit.
  localparam logic [2:0] CNT_LAST = 3'(BITS - 1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [BITS-1:0]  hi_q, hi_d;   // product high half / partial remainder
  logic [BITS-1:0]  lo_q, lo_d;   // multiplier -> product low half / dividend -> quotient
  logic [BITS-1:0]  b_q, b_d;     // multiplicand / divisor
  logic [BITS-1:0]  res_q, res_d;
  logic [RBITS-1:0] rd_q, rd_d;

  logic [BITS:0]    add_sum;
  logic [BITS:0]    shifted;
  logic [BITS:0]    diff;
  logic [BITS-1:0]  hi_step;
  logic [BITS-1:0]  lo_step;

  // One iteration of the datapath.
  // Multiply: {hi,lo} holds {partial product, remaining multiplier}; add the
  // multiplicand when lo[0] is set, then shift the whole pair right.
  // Divide: shift the next dividend bit into the remainder and subtract the
  // divisor if it fits. The remainder is always below the divisor, so the
  // top bit of diff is a reliable borrow flag. A zero divisor always "fits",
  // giving an all-ones quotient and the dividend as remainder.
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {BITS{1'b0}})};
    shifted = {hi_q, lo_q[BITS-1]};
    diff    = shifted - {1'b0, b_q};
    hi_step = hi_q;
    lo_step = lo_q;
    if (!op_q[1]) begin
      hi_step = add_sum[BITS:1];
      lo_step = {add_sum[0], lo_q[BITS-1:1]};
    end else if (!diff[BITS]) begin
      hi_step = diff[BITS-1:0];
      lo_step = {lo_q[BITS-2:0], 1'b1};
    end else begin
      hi_step = shifted[BITS-1:0];
      lo_step = {lo_q[BITS-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    res_d   = res_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.run && bus.start) begin
          op_d  = bus.op;
          rd_d  = bus.rd_in;
          cnt_d = '0;
          hi_d  = '0;
          if (bus.op[1]) begin
            lo_d = bus.rs1_val;
            b_d  = bus.rs2_val;
          end else begin
            lo_d = bus.rs2_val;
            b_d  = bus.rs1_val;
          end
          state_d = CALC;
        end
      end
      CALC: begin
        if (bus.run) begin
          hi_d  = hi_step;
          lo_d  = lo_step;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == CNT_LAST) begin
            // op[0] selects the high half (MULHU) or remainder (REMU).
            res_d   = op_q[0] ? hi_step : lo_step;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.we     = (state_q == DONE) && (rd_q != '0);
  assign bus.rd     = rd_q;
  assign bus.rd_din = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit: each accepted request pushes its
//   expected write-back and latency; a negedge monitor pops and compares
//   whenever done is seen on an advancing cycle.
module tb_muldiv_unit;
  localparam int BITS  = 8;
  localparam int RBITS = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if #(.BITS(BITS), .RBITS(RBITS)) bus ();

  muldiv_unit #(.BITS(BITS), .RBITS(RBITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] rd;
    logic [7:0] data;
    int         lat;
    int         acc;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      2'b00:   return p[7:0];
      2'b01:   return p[15:8];
      2'b10:   return (b == 8'd0) ? 8'hFF : a / b;
      default: return (b == 8'd0) ? a : a % b;
    endcase
  endfunction

  // Result monitor: one pop per advancing done cycle.
  always @(negedge clk) begin
    if (bus.done && bus.run) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_data"}, 32'(bus.rd_din), 32'(mon_e.data));
        check({mon_e.tag, "_rd"}, 32'(bus.rd), 32'(mon_e.rd));
        check({mon_e.tag, "_we"}, 32'(bus.we), 32'(mon_e.rd != 3'd0));
        check({mon_e.tag, "_latency"}, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  // All driving happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] rd, input int lat, input string tag,
                       output int acc);
    exp_t e;
    int   n;
    n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    if (bus.busy) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
    bus.op      = op;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    bus.start   = 1'b1;
    acc         = cyc;
    e.rd   = rd;
    e.data = model(op, a, b);
    e.lat  = lat;
    e.acc  = acc;
    e.tag  = tag;
    sb.push_back(e);
    tick();
    bus.start   = 1'b0;
    // Scramble inputs after acceptance; the result must not depend on them.
    bus.op      = 2'($urandom);
    bus.rs1_val = 8'($urandom);
    bus.rs2_val = 8'($urandom);
    bus.rd_in   = 3'($urandom);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    int acc;
    logic [7:0] held;
    logic [1:0] rop;
    logic [7:0] ra, rb;

    rst         = 1'b1;
    bus.run     = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    bus.rd_in   = '0;
    tick();
    tick();
    tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_we", 32'(bus.we), 32'd0);
    check("reset_rd", 32'(bus.rd), 32'd0);
    check("reset_rd_din", 32'(bus.rd_din), 32'd0);
    rst     = 1'b0;
    bus.run = 1'b1;
    tick();

    // Directed operations.
    issue(2'b00, 8'h0F, 8'h11, 3'd3, 9, "mul_0f_11", acc);
    check("busy_in_calc", 32'(bus.busy), 32'd1);
    drain("mul_0f_11");
    tick();
    tick();
    check("rd_din_hold", 32'(bus.rd_din), 32'hFF);
    issue(2'b01, 8'h0F, 8'h11, 3'd3, 9, "mulhu_0f_11", acc);
    issue(2'b01, 8'hFF, 8'hFF, 3'd1, 9, "mulhu_ff_ff", acc);
    issue(2'b00, 8'hFF, 8'hFF, 3'd2, 9, "mul_ff_ff", acc);
    issue(2'b10, 8'd200, 8'd7, 3'd4, 9, "divu_200_7", acc);
    issue(2'b11, 8'd200, 8'd7, 3'd4, 9, "remu_200_7", acc);
    issue(2'b10, 8'h5A, 8'h00, 3'd5, 9, "divu_5a_0", acc);
    issue(2'b11, 8'h5A, 8'h00, 3'd6, 9, "remu_5a_0", acc);
    drain("directed");

    // Stall 3 cycles in CALC, then 2 cycles in DONE.
    issue(2'b10, 8'hC8, 8'h0D, 3'd6, 14, "stall_divu", acc);
    tick();
    tick();
    bus.run = 1'b0;
    tick();
    tick();
    check("stall_calc_busy", 32'(bus.busy), 32'd1);
    tick();
    bus.run = 1'b1;
    while (cyc < acc + 11) tick();
    check("stall_not_early", 32'(bus.done), 32'd0);
    tick();
    check("stall_done_at_12", 32'(bus.done), 32'd1);
    bus.run = 1'b0;
    held    = bus.rd_din;
    tick();
    check("stall_done_hold", 32'(bus.done), 32'd1);
    check("stall_we_hold", 32'(bus.we), 32'd1);
    check("stall_rd_din_hold", 32'(bus.rd_din), 32'(held));
    tick();
    check("stall_done_hold2", 32'(bus.done), 32'd1);
    bus.run = 1'b1;
    drain("stall");
    check("stall_back_idle", 32'(bus.busy), 32'd0);

    // Start pulsed mid-calculation must be ignored and not queued.
    issue(2'b00, 8'h23, 8'h45, 3'd5, 9, "mul_ignore_start", acc);
    tick();
    tick();
    bus.op      = 2'b10;
    bus.rs1_val = 8'h99;
    bus.rs2_val = 8'h03;
    bus.rd_in   = 3'd2;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    drain("ignore_start");
    repeat (15) tick();
    check("no_queued_start", 32'(bus.busy), 32'd0);

    // Start while run=0 must not be accepted.
    bus.run   = 1'b0;
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;
    bus.run   = 1'b1;
    check("start_no_run", 32'(bus.busy), 32'd0);

    // rd = 0: done without a write.
    issue(2'b11, 8'h77, 8'h10, 3'd0, 9, "remu_rd0", acc);
    drain("rd0");

    // Reset mid-operation aborts it.
    issue(2'b00, 8'h12, 8'h34, 3'd7, 9, "mul_abort", acc);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_we", 32'(bus.we), 32'd0);
    check("abort_rd", 32'(bus.rd), 32'd0);
    check("abort_rd_din", 32'(bus.rd_din), 32'd0);
    repeat (15) tick();
    issue(2'b01, 8'h12, 8'h34, 3'd7, 9, "mulhu_after_rst", acc);
    drain("after_rst");

    // Random mix, back-to-back.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      issue(rop, ra, rb, 3'($urandom), 9, "random", acc);
    end
    drain("random");
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter BITS, default 8, operand/result width.
REQ-002 The block SHALL have parameter RBITS, default 3, destination register index width.
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port run  in  1  global advance enable; 0 freezes all state.
REQ-006 The block SHALL have port start  in  1  request a new operation.
REQ-007 The block SHALL have port op  in  2  00 MUL (low byte), 01 MULHU (high byte), 10 DIVU (quotient), 11 REMU (remainder).
REQ-008 The block SHALL have port rs1_val  in  BITS  operand A (dividend or multiplicand), taken from the register file rs1 read port.
REQ-009 The block SHALL have port rs2_val  in  BITS  operand B (divisor or multiplier), taken from the register file rs2 read port.
REQ-010 The block SHALL have port rd_in  in  RBITS  destination register index.
REQ-011 The block SHALL have port busy  out  1  operation in progress; start is ignored while it is high.
REQ-012 The block SHALL have port done  out  1  result valid; high for one advancing cycle.
REQ-013 The block SHALL have port we  out  1  register-file write enable.
REQ-014 The block SHALL have port rd  out  RBITS  register-file write index.
REQ-015 The block SHALL have port rd_din  out  BITS  register-file write data.

Function
REQ-016 The block SHALL implement the states IDLE, CALC and DONE, with a 3-bit iteration counter.
REQ-017 In IDLE, on a cycle with run=1 and start=1, the block SHALL capture op, rs1_val, rs2_val and rd_in, clear the counter, and go to CALC.
REQ-018 In CALC, each cycle with run=1 SHALL perform one iteration: shift-add for op[1]=0, restoring shift-subtract for op[1]=1.
REQ-019 When the counter reaches 7 in CALC with run=1, the block SHALL go to DONE.
REQ-020 In DONE with run=1, the block SHALL return to IDLE.
REQ-021 Latency SHALL be exactly 9 advancing cycles: accept edge in cycle T, CALC for T+1..T+8, done=1 during T+9.
REQ-022 A new start SHALL be accepted no earlier than T+10.
REQ-023 busy SHALL equal 1 in CALC and DONE and 0 in IDLE; done SHALL equal 1 only in DONE.
REQ-024 we SHALL equal done AND (rd != 0).
REQ-025 rd SHALL hold the captured rd_in from the accept cycle until the next accept.
REQ-026 The multiply SHALL form a 2*BITS-bit unsigned product; MUL returns product[BITS-1:0] and MULHU returns product[2*BITS-1:BITS].
REQ-027 Divide SHALL be unsigned; DIVU returns the quotient and REMU returns the remainder.
REQ-028 On divisor 0, DIVU SHALL return all ones (0xFF) and REMU SHALL return the dividend, per RISC-V.
REQ-029 rd_din SHALL update only on the transition into DONE and SHALL hold that value until the next completion.
REQ-030 With run=0, state, counter, datapath registers and all outputs SHALL hold.
REQ-031 A stall with run=0 during DONE SHALL keep done and we high until a cycle with run=1.
REQ-032 start asserted while busy=1 SHALL be ignored with no side effects, and SHALL NOT be queued.
REQ-033 start asserted with run=0 SHALL NOT be accepted.
REQ-034 Operand inputs SHALL be ignored after the accept cycle; later changes SHALL NOT affect the result.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL enter IDLE with counter=0, busy=0, done=0, we=0, rd=0, rd_din=0, regardless of run.
REQ-036 rst SHALL take priority over start and run.
REQ-037 rst asserted mid-operation SHALL abort the operation, with no done or we pulse afterwards.

Verification
REQ-038 The bench SHALL cover MUL 0x0F*0x11 with rd=3: done and we exactly 9 cycles after accept, rd_din=0xFF, rd=3; MULHU with the same operands gives rd_din=0x00.
REQ-039 The bench SHALL cover MULHU 0xFF*0xFF -> 0xFE, and MUL 0xFF*0xFF -> 0x01.
REQ-040 The bench SHALL cover DIVU 200/7 -> 0x1C, REMU 200/7 -> 0x04, DIVU 0x5A/0 -> 0xFF, and REMU 0x5A/0 -> 0x5A.
REQ-041 The bench SHALL cover run=0 for 3 cycles during CALC: done arrives 12 cycles after accept with a correct result; run=0 in DONE holds done/we high.
REQ-042 The bench SHALL cover start pulsed during CALC with different operands: ignored, first result unchanged; rd_in=0: done=1 with we=0.
REQ-043 The bench SHALL cover rst during CALC: next cycle busy=0, done=0, rd_din=0, no later done; a fresh start then completes normally.
